ecc_scalar_mult_seq: RTL and testbench

//  Sequential, parametrised elliptic-curve scalar multiplier R = k*P over GF(p), affine coords,

---
 rtl/ecc_pkg.sv | 29 ++
 rtl/ecc_point_add_seq.sv | 141 ++++++++++++++
 rtl/ecc_scalar_mult_seq.sv | 148 ++++++++++++++
 tb/tb_ecc_scalar_mult_seq.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared constants for the sequential scalar multiplier and its point-arithmetic unit.
package ecc_pkg;

    localparam logic OP_DBL = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Scalar-multiplier control states
    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_LOAD   = 4'd1;
    localparam logic [3:0] ST_SCAN   = 4'd2;
    localparam logic [3:0] ST_DBL    = 4'd3;
    localparam logic [3:0] ST_DBL_W  = 4'd4;
    localparam logic [3:0] ST_ADDCHK = 4'd5;
    localparam logic [3:0] ST_ADD_W  = 4'd6;
    localparam logic [3:0] ST_NEXT   = 4'd7;
    localparam logic [3:0] ST_FIN    = 4'd8;

    // Point-arithmetic unit states
    localparam logic [3:0] A_IDLE = 4'd0;
    localparam logic [3:0] A_SQ   = 4'd1;
    localparam logic [3:0] A_NUM  = 4'd2;
    localparam logic [3:0] A_EXP  = 4'd3;
    localparam logic [3:0] A_CHK  = 4'd4;
    localparam logic [3:0] A_LAM  = 4'd5;
    localparam logic [3:0] A_X3   = 4'd6;
    localparam logic [3:0] A_Y3   = 4'd7;
    localparam logic [3:0] A_DONE = 4'd8;

endpackage

// File: rtl/ecc_point_add_seq.sv
// Sequential affine point add/double over GF(p) with one shared modular multiplier.
// The denominator inverse is computed as den^(p-2) and checked by den*inv == 1.
module ecc_point_add_seq
    import ecc_pkg::*;
#(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             op,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic             inf1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    input  logic             inf2,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] rx,
    output logic [WIDTH-1:0] ry,
    output logic             r_inf
);

    typedef logic [WIDTH-1:0] fe_t;

    function automatic fe_t addm(fe_t u, fe_t v, fe_t m);
        logic [WIDTH:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[WIDTH-1:0];
    endfunction

    function automatic fe_t subm(fe_t u, fe_t v, fe_t m);
        return (u >= v) ? u - v : u + (m - v);
    endfunction

    function automatic fe_t mulmod(fe_t u, fe_t v, fe_t m);
        logic [2*WIDTH-1:0] t;
        t = (2*WIDTH)'(u) * (2*WIDTH)'(v);
        t = t % (2*WIDTH)'(m);
        return t[WIDTH-1:0];
    endfunction

    logic [3:0] st;
    fe_t  x1q, y1q, x2q, aq, pq, num, den, inv, bse, e, lam, x3;
    logic ph;
    fe_t  mul_a, mul_b, prod;
    logic is_dbl;

    assign is_dbl = (op == OP_DBL) || (x1 == x2 && y1 == y2);
    assign done   = (st == A_DONE);

    always_comb begin
        mul_a = x1q;
        mul_b = x1q;
        case (st)
            A_EXP: begin
                mul_a = ph ? bse : inv;
                mul_b = bse;
            end
            A_CHK: begin mul_a = den; mul_b = inv; end
            A_LAM: begin mul_a = num; mul_b = inv; end
            A_X3:  begin mul_a = lam; mul_b = lam; end
            A_Y3:  begin mul_a = lam; mul_b = subm(x1q, x3, pq); end
            default: ;
        endcase
    end

    assign prod = mulmod(mul_a, mul_b, pq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= A_IDLE;
            x1q <= '0; y1q <= '0; x2q <= '0; aq <= '0; pq <= '0;
            num <= '0; den <= '0; inv <= '0; bse <= '0; e <= '0; lam <= '0; x3 <= '0;
            ph <= 1'b0;
            rx <= '0; ry <= '0; r_inf <= 1'b0; err <= 1'b0;
        end else begin
            case (st)
                A_IDLE: if (req) begin
                    x1q <= x1; y1q <= y1; aq <= a; pq <= p; err <= 1'b0;
                    x2q <= is_dbl ? x1 : x2;
                    if (inf1) begin
                        rx <= x2; ry <= y2; r_inf <= inf2; st <= A_DONE;
                    end else if (inf2) begin
                        rx <= x1; ry <= y1; r_inf <= 1'b0; st <= A_DONE;
                    end else if ((is_dbl && y1 == '0) || (!is_dbl && x1 == x2)) begin
                        // Vertical tangent or Q + (-Q)
                        rx <= '0; ry <= '0; r_inf <= 1'b1; st <= A_DONE;
                    end else if (is_dbl) begin
                        st <= A_SQ;
                    end else begin
                        num <= subm(y2, y1, p);
                        den <= subm(x2, x1, p);
                        st  <= A_NUM;
                    end
                end
                A_SQ: begin
                    num <= addm(addm(addm(prod, prod, pq), prod, pq), aq, pq);
                    den <= addm(y1q, y1q, pq);
                    st  <= A_NUM;
                end
                A_NUM: begin
                    inv <= fe_t'(1);
                    bse <= den;
                    e   <= pq - fe_t'(2);
                    ph  <= 1'b0;
                    st  <= A_EXP;
                end
                A_EXP: begin
                    if (!ph) begin
                        if (e[0]) inv <= prod;
                        ph <= 1'b1;
                    end else begin
                        bse <= prod;
                        e   <= e >> 1;
                        ph  <= 1'b0;
                        if (e[WIDTH-1:1] == '0) st <= A_CHK;
                    end
                end
                A_CHK: begin
                    if (prod != fe_t'(1)) begin
                        err <= 1'b1; r_inf <= 1'b1; rx <= '0; ry <= '0; st <= A_DONE;
                    end else begin
                        st <= A_LAM;
                    end
                end
                A_LAM: begin lam <= prod; st <= A_X3; end
                A_X3:  begin x3 <= subm(subm(prod, x1q, pq), x2q, pq); st <= A_Y3; end
                A_Y3: begin
                    rx <= x3; ry <= subm(prod, y1q, pq); r_inf <= 1'b0; st <= A_DONE;
                end
                default: st <= A_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ecc_scalar_mult_seq.sv
// Left-to-right double-and-add scalar multiplier R = k*P; infinity cases are
// resolved here so the point unit only sees finite operands.
module ecc_scalar_mult_seq
    import ecc_pkg::*;
#(
    parameter int WIDTH  = 256,
    parameter int KWIDTH = WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KWIDTH-1:0] k,
    input  logic [WIDTH-1:0]  px,
    input  logic [WIDTH-1:0]  py,
    input  logic              p_inf,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  p,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  rx,
    output logic [WIDTH-1:0]  ry,
    output logic              r_inf,
    output logic              err
);

    localparam int IW = (KWIDTH > 1) ? $clog2(KWIDTH) : 1;

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inf;
    } point_t;

    logic [3:0]        state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [KWIDTH-1:0] k_q;
    logic [WIDTH-1:0]  a_q, mod_q;
    point_t            base, r, r_nx;
    logic              err_nx;
    logic              add_req, add_op, add_done, add_err, add_inf;
    logic [WIDTH-1:0]  add_x, add_y;

    // Valid/ready: req is a one-cycle pulse from DBL/ADDCHK; the unit answers with a
    // one-cycle done carrying result/err while this FSM waits in DBL_W/ADD_W.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        r_nx     = r;
        err_nx   = 1'b0;
        add_req  = 1'b0;
        add_op   = OP_DBL;
        case (state)
            ST_IDLE: if (start) state_nx = ST_LOAD;
            ST_LOAD: begin
                r_nx     = '0;
                r_nx.inf = 1'b1;
                idx_nx   = IW'(KWIDTH - 1);
                state_nx = ST_SCAN;
            end
            ST_SCAN: state_nx = (k_q == '0 || base.inf) ? ST_FIN : ST_DBL;
            ST_DBL: begin
                if (r.inf) begin
                    state_nx = ST_ADDCHK;
                end else begin
                    add_req  = 1'b1;
                    state_nx = ST_DBL_W;
                end
            end
            ST_DBL_W: if (add_done) begin
                if (add_err) begin
                    err_nx = 1'b1; state_nx = ST_FIN;
                end else begin
                    r_nx = '{x: add_x, y: add_y, inf: add_inf}; state_nx = ST_ADDCHK;
                end
            end
            ST_ADDCHK: begin
                if (!k_q[idx]) begin
                    state_nx = ST_NEXT;
                end else if (r.inf) begin
                    r_nx = base; state_nx = ST_NEXT;
                end else begin
                    add_req = 1'b1; add_op = OP_ADD; state_nx = ST_ADD_W;
                end
            end
            ST_ADD_W: if (add_done) begin
                if (add_err) begin
                    err_nx = 1'b1; state_nx = ST_FIN;
                end else begin
                    r_nx = '{x: add_x, y: add_y, inf: add_inf}; state_nx = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx == '0) begin
                    state_nx = ST_FIN;
                end else begin
                    idx_nx = idx - 1'b1; state_nx = ST_DBL;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx <= '0; k_q <= '0; a_q <= '0; mod_q <= '0; base <= '0; r <= '0;
            busy <= 1'b0; done <= 1'b0; err <= 1'b0;
            rx <= '0; ry <= '0; r_inf <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            r     <= r_nx;
            if (state == ST_IDLE && start) begin
                k_q <= k; a_q <= a; mod_q <= p;
                base <= '{x: px, y: py, inf: p_inf};
            end
            busy <= (state_nx != ST_IDLE) && (state_nx != ST_FIN);
            done <= (state_nx == ST_FIN);
            if (state_nx == ST_FIN) begin
                err   <= err_nx;
                r_inf <= err_nx | r_nx.inf;
                rx    <= (err_nx | r_nx.inf) ? '0 : r_nx.x;
                ry    <= (err_nx | r_nx.inf) ? '0 : r_nx.y;
            end
        end
    end

    ecc_point_add_seq #(.WIDTH(WIDTH)) u_add (
        .clk   (clk),
        .rst   (rst),
        .req   (add_req),
        .op    (add_op),
        .x1    (r.x),
        .y1    (r.y),
        .inf1  (r.inf),
        .x2    (base.x),
        .y2    (base.y),
        .inf2  (base.inf),
        .a     (a_q),
        .p     (mod_q),
        .done  (add_done),
        .err   (add_err),
        .rx    (add_x),
        .ry    (add_y),
        .r_inf (add_inf)
    );

endmodule

// File: tb/tb_ecc_scalar_mult_seq.sv
// Directed bench on y^2 = x^3 + 2x + 2 over GF(17), G = (5,1) of order 19.
module tb_ecc_scalar_mult_seq;
    import ecc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] k = '0, px = '0, py = '0, a = 8'd2, p = 8'd17;
    logic       p_inf = 1'b0;
    logic       busy, done, r_inf, err;
    logic [7:0] rx, ry;

    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    int lat;
    int req_before;
    int extra;

    ecc_scalar_mult_seq #(.WIDTH(8), .KWIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .k     (k),
        .px    (px),
        .py    (py),
        .p_inf (p_inf),
        .a     (a),
        .p     (p),
        .busy  (busy),
        .done  (done),
        .rx    (rx),
        .ry    (ry),
        .r_inf (r_inf),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (dut.add_req) req_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic start_op(input logic [7:0] kk, input logic [7:0] x, input logic [7:0] y,
                            input logic pi);
        @(negedge clk);
        k = kk; px = x; py = y; p_inf = pi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // lat counts cycles from the cycle start was high to the cycle done is seen
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (cyc < 3000 && !done) begin
            @(negedge clk);
            cyc++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [7:0] ex, input logic [7:0] ey,
                                input logic einf);
        check({tag, "_rx"}, {24'd0, rx}, {24'd0, ex});
        check({tag, "_ry"}, {24'd0, ry}, {24'd0, ey});
        check({tag, "_inf"}, {31'd0, r_inf}, {31'd0, einf});
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx", {24'd0, rx}, 32'd0);
        check("rst_ry", {24'd0, ry}, 32'd0);
        check("rst_inf", {31'd0, r_inf}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_op(8'd1, 8'd5, 8'd1, 1'b0);
        check("k1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("k1_busy_at_done", {31'd0, busy}, 32'd0);
        check_result("k1", 8'd5, 8'd1, 1'b0);

        start_op(8'd2, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check_result("k2", 8'd6, 8'd3, 1'b0);

        start_op(8'd3, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check_result("k3", 8'd10, 8'd6, 1'b0);

        start_op(8'd18, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check_result("k18", 8'd5, 8'd16, 1'b0);

        start_op(8'd19, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check_result("k19", 8'd0, 8'd0, 1'b1);

        // Zero scalar: no adder traffic, done three cycles after start
        req_before = req_cnt;
        start_op(8'd0, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check("k0_latency", lat, 32'd3);
        check_result("k0", 8'd0, 8'd0, 1'b1);
        check("k0_no_req", req_cnt - req_before, 32'd0);

        req_before = req_cnt;
        start_op(8'd5, 8'd5, 8'd1, 1'b1);
        wait_done(lat);
        check("pinf_latency", lat, 32'd3);
        check_result("pinf", 8'd0, 8'd0, 1'b1);
        check("pinf_no_req", req_cnt - req_before, 32'd0);

        // Second start while busy must be dropped
        start_op(8'd2, 8'd5, 8'd1, 1'b0);
        @(negedge clk);
        k = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check_result("ignore", 8'd6, 8'd3, 1'b0);
        extra = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignore_single_done", extra, 32'd0);

        // Reset while waiting on a doubling
        start_op(8'd3, 8'd5, 8'd1, 1'b0);
        lat = 0;
        while (lat < 500 && dut.state != ST_DBL_W) begin
            @(negedge clk);
            lat++;
        end
        check("reach_dbl_w", {28'd0, dut.state}, {28'd0, ST_DBL_W});
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_rx", {24'd0, rx}, 32'd0);
        check("mid_rst_ry", {24'd0, ry}, 32'd0);
        check("mid_rst_req", {31'd0, dut.add_req}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        start_op(8'd3, 8'd5, 8'd1, 1'b0);
        wait_done(lat);
        check_result("post_rst_k3", 8'd10, 8'd6, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
